// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver.
// Captures a BCD frame once per scan cycle, strobes one digit per slot with
// an all-off guard interval at the start of each slot, and optionally blanks
// leading zeros. Segment and digit-enable outputs are active-low.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 12500,
    parameter int GUARD    = 64
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic        en,
    input  logic        lzb_en,
    input  logic [15:0] bcd,
    output logic [6:0]  seg,
    output logic [3:0]  key0,
    output logic        frame_done
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int GUARD_W = $clog2(GUARD + 1);
    localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(SCAN_DIV - 1);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD);
    localparam logic [6:0]         SEG_OFF    = 7'b1111111;
    localparam logic [3:0]         KEY_OFF    = 4'b1111;

    // Active-low {a,b,c,d,e,f,g} pattern for one nibble; non-BCD codes are dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b0000001;
            4'd1:    pattern = 7'b1001111;
            4'd2:    pattern = 7'b0010010;
            4'd3:    pattern = 7'b0000110;
            4'd4:    pattern = 7'b1001100;
            4'd5:    pattern = 7'b0100100;
            4'd6:    pattern = 7'b1100000;
            4'd7:    pattern = 7'b0001111;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0001100;
            default: pattern = 7'b1111111;
        endcase
        return pattern;
    endfunction

    logic [PRESC_W-1:0] presc_r;
    logic [1:0]         idx_r;
    logic [GUARD_W-1:0] guard_r;
    logic [15:0]        shadow_r;
    logic [6:0]         seg_r;
    logic [3:0]         key0_r;
    logic               frame_done_r;

    logic               tick_s;
    logic               frame_end_s;
    logic [3:0]         digit_s;
    logic               zero_3_s;
    logic               zero_32_s;
    logic               zero_321_s;
    logic               lz_blank_s;
    logic [6:0]         seg_next_s;
    logic [3:0]         key0_next_s;

    assign tick_s      = en && (presc_r == PRESC_MAX);
    assign frame_end_s = tick_s && (idx_r == 2'd3);

    // Leading-zero chain: digit i is a leading zero if it and all higher digits are 0.
    assign zero_3_s   = (shadow_r[15:12] == 4'd0);
    assign zero_32_s  = zero_3_s  && (shadow_r[11:8] == 4'd0);
    assign zero_321_s = zero_32_s && (shadow_r[7:4]  == 4'd0);

    // Slot prescaler: free-runs 0..SCAN_DIV-1 while enabled, holds while disabled.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            presc_r <= '0;
        end else if (en) begin
            if (presc_r == PRESC_MAX) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PRESC_W'(1);
            end
        end else begin
            presc_r <= presc_r;
        end
    end

    // Digit slot index advances once per slot tick.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            idx_r <= 2'd0;
        end else if (tick_s) begin
            idx_r <= idx_r + 2'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Guard counter: reload at each slot start, count down to zero while enabled.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            guard_r <= GUARD_LOAD;
        end else if (tick_s) begin
            guard_r <= GUARD_LOAD;
        end else if (en && (guard_r != '0)) begin
            guard_r <= guard_r - GUARD_W'(1);
        end else begin
            guard_r <= guard_r;
        end
    end

    // Frame capture: bcd is sampled only at the end of a full frame so a frame never tears.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            shadow_r     <= 16'h0000;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= frame_end_s;
            if (frame_end_s) begin
                shadow_r <= bcd;
            end else begin
                shadow_r <= shadow_r;
            end
        end
    end

    // Select the captured digit and its leading-zero status for the current slot.
    always_comb begin
        digit_s    = 4'd0;
        lz_blank_s = 1'b0;
        case (idx_r)
            2'd0: begin
                digit_s    = shadow_r[3:0];
                lz_blank_s = 1'b0;
            end
            2'd1: begin
                digit_s    = shadow_r[7:4];
                lz_blank_s = lzb_en && zero_321_s;
            end
            2'd2: begin
                digit_s    = shadow_r[11:8];
                lz_blank_s = lzb_en && zero_32_s;
            end
            2'd3: begin
                digit_s    = shadow_r[15:12];
                lz_blank_s = lzb_en && zero_3_s;
            end
            default: begin
                digit_s    = 4'd0;
                lz_blank_s = 1'b0;
            end
        endcase
    end

    // Next output values: dark during guard or when disabled, else strobe the slot digit.
    always_comb begin
        seg_next_s  = SEG_OFF;
        key0_next_s = KEY_OFF;
        if (en && (guard_r == '0)) begin
            case (idx_r)
                2'd0:    key0_next_s = 4'b1110;
                2'd1:    key0_next_s = 4'b1101;
                2'd2:    key0_next_s = 4'b1011;
                2'd3:    key0_next_s = 4'b0111;
                default: key0_next_s = KEY_OFF;
            endcase
            if (lz_blank_s) begin
                seg_next_s = SEG_OFF;
            end else begin
                seg_next_s = bcd_to_seg(digit_s);
            end
        end else begin
            seg_next_s  = SEG_OFF;
            key0_next_s = KEY_OFF;
        end
    end

    // Output registers keep the pins glitch-free.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            seg_r  <= SEG_OFF;
            key0_r <= KEY_OFF;
        end else begin
            seg_r  <= seg_next_s;
            key0_r <= key0_next_s;
        end
    end

    assign seg        = seg_r;
    assign key0       = key0_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with SCAN_DIV=8, GUARD=2.
// Stimulus pushes the hand-computed per-cycle output expectation for each frame
// into a queue; a negedge monitor pops one entry per cycle and compares.
module tb_seg7_scan_driver;

    localparam int SCAN_DIV = 8;
    localparam int GUARD    = 2;

    localparam logic [6:0] DARK = 7'b1111111;
    localparam logic [3:0] KOFF = 4'b1111;

    logic        clk_50mhz = 1'b0;
    logic        rst       = 1'b1;
    logic        en        = 1'b1;
    logic        lzb_en    = 1'b0;
    logic [15:0] bcd       = 16'h0000;
    logic [6:0]  seg;
    logic [3:0]  key0;
    logic        frame_done;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] key;
        logic       fd;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
        .clk_50mhz  (clk_50mhz),
        .rst        (rst),
        .en         (en),
        .lzb_en     (lzb_en),
        .bcd        (bcd),
        .seg        (seg),
        .key0       (key0),
        .frame_done (frame_done)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic step();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic push(input logic [6:0] s, input logic [3:0] k, input logic f, input string n);
        exp_t e;
        e.seg  = s;
        e.key  = k;
        e.fd   = f;
        e.name = n;
        exp_q.push_back(e);
    endtask

    function automatic logic [3:0] key_for(input int k);
        case (k)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            3:       return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    // One scan frame: e3..e0 are the expected segment patterns of the currently
    // captured digits; b is the bcd to present for capture at the frame end.
    // Optional: mid-frame bcd change, an en=0 gap after entry gap_at, or a reset after entry rst_at.
    task automatic run_frame(input logic lzb, input logic [15:0] b,
                             input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0,
                             input int mid_at, input logic [15:0] mid_b,
                             input int gap_at, input int gap_len,
                             input int rst_at, input string name);
        logic [6:0] e [4];
        int last;
        int nsteps;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        lzb_en = lzb;
        bcd    = b;
        last   = (rst_at > 0) ? rst_at : 32;
        for (int j = 1; j <= last; j++) begin
            int k;
            int p;
            k = (j - 1) / 8;
            p = (j - 1) % 8;
            if (p < GUARD) push(DARK, KOFF, 1'b0, $sformatf("%s_s%0d_guard", name, k));
            else           push(e[k], key_for(k), (j == 32), $sformatf("%s_s%0d_lit", name, k));
            if (j == gap_at) begin
                for (int g = 0; g < gap_len; g++) push(DARK, KOFF, 1'b0, {name, "_en_off"});
            end
        end
        if (rst_at > 0) push(DARK, KOFF, 1'b0, {name, "_rst"});
        nsteps = last + gap_len + ((rst_at > 0) ? 1 : 0);
        for (int s = 1; s <= nsteps; s++) begin
            step();
            if (s == mid_at) bcd = mid_b;
            if (gap_len > 0 && s == gap_at) en = 1'b0;
            if (gap_len > 0 && s == gap_at + gap_len) en = 1'b1;
            if (rst_at > 0 && s == rst_at) rst = 1'b1;
            if (rst_at > 0 && s == rst_at + 1) rst = 1'b0;
        end
    endtask

    // Monitor: one expected entry per cycle, compared away from the active edge.
    always @(negedge clk_50mhz) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({seg, key0, frame_done} !== {e.seg, e.key, e.fd}) begin
                errors++;
                $display("FAIL %s: got seg=%b key0=%b fd=%b, expected seg=%b key0=%b fd=%b",
                         e.name, seg, key0, frame_done, e.seg, e.key, e.fd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        rst = 1'b0;
        push(DARK, KOFF, 1'b0, "reset_state");
        // Frame 1: shadow=0000 after reset, capture 1234
        run_frame(1'b0, 16'h1234, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001,
                  0, 16'h0, 0, 0, 0, "f1_zero");
        // Frame 2: shows 1234
        run_frame(1'b0, 16'h0050, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                  0, 16'h0, 0, 0, 0, "f2_1234");
        // Frame 3: 0050 with leading-zero blanking
        run_frame(1'b1, 16'h0000, DARK, DARK, 7'b0100100, 7'b0000001,
                  0, 16'h0, 0, 0, 0, "f3_lzb_0050");
        // Frame 4: 0000 with blanking -> single 0
        run_frame(1'b1, 16'hA0F9, DARK, DARK, DARK, 7'b0000001,
                  0, 16'h0, 0, 0, 0, "f4_lzb_0000");
        // Frame 5: non-BCD nibbles A0F9
        run_frame(1'b1, 16'h1111, DARK, 7'b0000001, DARK, 7'b0001100,
                  0, 16'h0, 0, 0, 0, "f5_nonbcd");
        // Frame 6: shows 1111 while bcd changes to 2222 during slot 1
        run_frame(1'b0, 16'h1111, 7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111,
                  10, 16'h2222, 0, 0, 0, "f6_coherent");
        // Frame 7: 2222 only after frame_done
        run_frame(1'b0, 16'h2222, 7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010,
                  0, 16'h0, 0, 0, 0, "f7_2222");
        // Frame 8: en dropped for 20 cycles mid slot 1
        run_frame(1'b0, 16'h2222, 7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010,
                  0, 16'h0, 12, 20, 0, "f8_en_gap");
        // Frame 9: reset while slot 2 is lit
        run_frame(1'b0, 16'h9876, 7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010,
                  0, 16'h0, 0, 0, 20, "f9_mid_rst");
        // Frame 10: post-reset shadow=0000
        run_frame(1'b0, 16'h9876, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001,
                  0, 16'h0, 0, 0, 0, "f10_post_rst");
        // Frame 11: shows 9876
        run_frame(1'b0, 16'h9876, 7'b0001100, 7'b0000000, 7'b0001111, 7'b1100000,
                  0, 16'h0, 0, 0, 0, "f11_9876");
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Four-digit multiplexed 7-segment display driver.
- Sits directly downstream of the digit counters. It takes four BCD digits and drives the shared, active-low `seg` bus and the active-low `key0` digit enables.
- It adds time-multiplexed scanning, frame-coherent input capture, anti-ghosting guard blanking and optional leading-zero blanking. This lets the board show four digits instead of one.

Parameters:
- SCAN_DIV, 12500, clk_50mhz cycles per digit slot (4 kHz slot rate, 1 kHz frame rate at 50 MHz); must be >= 4.
- GUARD, 64, cycles at the start of each slot with all digits off; must satisfy 1 <= GUARD < SCAN_DIV.

Ports:
- clk_50mhz  input  1   system clock
- rst  input  1   synchronous reset, active-high
- en  input  1   display enable; 0 = dark display
- lzb_en  input  1   1 = leading-zero blanking on
- bcd  input  16  digits: [15:12]=digit3 (leftmost, most significant) … [3:0]=digit0
- seg  output  7   segments {a,b,c,d,e,f,g}, active-low
- key0  output  4   digit enables, active-low; key0[i] drives digit i
- frame_done  output  1   one-cycle pulse when a full 4-digit frame completes

Behaviour:
- One clock and one reset: clk_50mhz, with rst synchronous and active-high. All state updates on the rising edge of clk_50mhz; seg, key0 and frame_done are registered.
- Reset values: seg=7'b1111111, key0=4'b1111, frame_done=0, prescaler=0, idx=0, guard counter=GUARD, shadow=16'h0000.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted when prescaler==SCAN_DIV-1 and en=1.
- Slot index idx (2 bits):
  - On tick, idx increments 0→1→2→3→0.
  - On tick with idx==3: shadow<=bcd, and frame_done=1 in the next cycle only.
  - bcd is sampled only at that point. Mid-frame changes to bcd are invisible until the next frame.
- Guard counter:
  - Reloads to GUARD on every tick; otherwise decrements to 0 and holds.
  - While it is nonzero, next key0=4'b1111 and seg=7'b1111111.
- Active display, when guard==0 and en=1:
  - key0 = all ones except key0[idx]=0.
  - seg = decode of shadow digit idx.
- Decode (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=1100000, 7=0001111, 8=0000000, 9=0001100
  - 10–15 = 1111111 (blank); key0 is still driven low for that digit.
- Leading-zero blanking, when lzb_en=1:
  - Digit i (i=3,2,1) is blanked (seg=1111111) when shadow digit i and all higher shadow digits are 0.
  - Digit 0 is never blanked by this rule, so value 0 shows a single "0".
  - Non-BCD nibbles count as nonzero.
- en=0:
  - Prescaler, idx and guard hold their values; shadow is not updated; frame_done=0.
  - Outputs are forced to key0=1111 and seg=1111111 starting the next cycle.
  - On return to en=1, scanning resumes from the held state.
- Latency: a change of idx or guard is reflected on seg/key0 one cycle later.
- Priority: rst overrides everything. A tick and a guard reload in the same cycle are consistent by construction.
- After reset, the display stays dark for GUARD cycles, then shows digit 0 of shadow=0000.

Test Plan:
- All cases use SCAN_DIV=8, GUARD=2.
- Reset mid-slot: assert rst at idx=2 with lit outputs → the next cycle shows seg=1111111, key0=1111, frame_done=0. After release, digit 0 shows 0000001 from cycle GUARD+1 onward.
- bcd=16'h1234, lzb_en=0 → repeating slots, each with 2 dark cycles then 6 lit cycles:
  - key0=1110 with seg=1001100
  - key0=1101 with seg=0000110
  - key0=1011 with seg=0010010
  - key0=0111 with seg=1001111
  - frame_done pulses once every 32 cycles.
- lzb_en=1:
  - bcd=16'h0050 → digits 3 and 2 show 1111111 (key0 still strobed), digit 1 shows 0100100, digit 0 shows 0000001.
  - bcd=16'h0000 → only digit 0 lit with 0000001.
- Non-BCD nibbles: bcd=16'hA0F9 → digits 3 and 1 show 1111111, digit 2 shows 0000001, digit 0 shows 0001100.
- Frame coherence: change bcd from 1111 to 2222 while idx=1 → the remaining slots of that frame still show 1001111. All slots show 0010010 only after the next frame_done.
- Enable gating: drop en for 20 cycles mid-slot → key0=1111, seg=1111111, no frame_done, idx unchanged. On re-enable, the same slot resumes and the frame completes with correct timing.
